// File: rtl/fetch_issue.sv
// Instruction-fetch issue stage: owns the fetch PC, keeps one instruction-bus
// request in flight, and feeds decode through an output register plus skid slot.
module fetch_issue #(
    parameter logic [63:0] PCINIT = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_nxt,
    output logic [63:0] pc,
    output logic        pc_hold,
    input  logic        flush,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        dec_valid,
    output logic [63:0] dec_pc,
    output logic [31:0] dec_instr,
    input  logic        dec_ready
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [ILEN-1:0] skid_instr_q, skid_instr_d;
    logic            dec_valid_q, dec_valid_d;
    logic [XLEN-1:0] dec_pc_q, dec_pc_d;
    logic [ILEN-1:0] dec_instr_q, dec_instr_d;

    logic            slot_free_c;
    logic            hold_c;
    logic            req_c;

    assign slot_free_c = !dec_valid_q || dec_ready;

    // Next-state, datapath updates and request/hold decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        redir_d      = redir_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        dec_valid_d  = dec_valid_q && !dec_ready;
        dec_pc_d     = dec_pc_q;
        dec_instr_d  = dec_instr_q;
        hold_c       = 1'b1;
        req_c        = 1'b0;

        case (state_q)
            ST_REQ: begin
                req_c = 1'b1;
                if (iresp_data_ok) begin
                    if (flush) begin
                        pc_d       = pc_nxt;
                        req_addr_d = pc_nxt;
                        hold_c     = 1'b0;
                    end else if (slot_free_c) begin
                        dec_valid_d = 1'b1;
                        dec_pc_d    = pc_q;
                        dec_instr_d = iresp_data;
                        pc_d        = pc_nxt;
                        req_addr_d  = pc_nxt;
                        hold_c      = 1'b0;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = iresp_data;
                        state_d      = ST_HOLD;
                    end
                end else if (flush) begin
                    // Request stays on the bus; its answer is dropped later.
                    redir_d = pc_nxt;
                    pc_d    = pc_nxt;
                    hold_c  = 1'b0;
                    state_d = ST_DROP;
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    pc_d         = pc_nxt;
                    req_addr_d   = pc_nxt;
                    hold_c       = 1'b0;
                    state_d      = ST_REQ;
                end else if (dec_ready) begin
                    dec_valid_d = 1'b1;
                    dec_pc_d    = skid_pc_q;
                    dec_instr_d = skid_instr_q;
                    pc_d        = pc_nxt;
                    req_addr_d  = pc_nxt;
                    hold_c      = 1'b0;
                    state_d     = ST_REQ;
                end
            end

            ST_DROP: begin
                req_c = 1'b1;
                if (iresp_data_ok) begin
                    state_d = ST_REQ;
                    if (flush) begin
                        pc_d       = pc_nxt;
                        req_addr_d = pc_nxt;
                        hold_c     = 1'b0;
                    end else begin
                        req_addr_d = redir_q;
                    end
                end else if (flush) begin
                    redir_d = pc_nxt;
                    pc_d    = pc_nxt;
                    hold_c  = 1'b0;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase

        // A redirect always invalidates whatever decode would see next.
        if (flush) begin
            dec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= PCINIT;
            req_addr_q   <= PCINIT;
            redir_q      <= PCINIT;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            dec_valid_q  <= 1'b0;
            dec_pc_q     <= '0;
            dec_instr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            redir_q      <= redir_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            dec_valid_q  <= dec_valid_d;
            dec_pc_q     <= dec_pc_d;
            dec_instr_q  <= dec_instr_d;
        end
    end

    // Request is suppressed during reset even though state already reads REQ.
    assign ireq_valid = req_c && !reset;
    assign ireq_addr  = req_addr_q;
    assign pc         = pc_q;
    assign pc_hold    = hold_c;
    assign dec_valid  = dec_valid_q;
    assign dec_pc     = dec_pc_q;
    assign dec_instr  = dec_instr_q;

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: zero-wait streaming, backpressure, DROP redirects, reset.
module tb_fetch_issue;

    logic        clk;
    logic        reset;
    logic [63:0] pc_nxt;
    logic [63:0] pc;
    logic        pc_hold;
    logic        flush;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dec_valid;
    logic [63:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;

    logic        zw;
    logic        ok_m;
    logic [63:0] flush_tgt;

    int checks;
    int errors;

    fetch_issue #(.PCINIT(64'h8000_0000)) dut (
        .clk(clk),
        .reset(reset),
        .pc_nxt(pc_nxt),
        .pc(pc),
        .pc_hold(pc_hold),
        .flush(flush),
        .ireq_valid(ireq_valid),
        .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .dec_valid(dec_valid),
        .dec_pc(dec_pc),
        .dec_instr(dec_instr),
        .dec_ready(dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple PC select and bus: the word returned encodes its own address.
    assign pc_nxt        = flush ? flush_tgt : pc + 64'd4;
    assign iresp_data_ok = zw ? ireq_valid : ok_m;
    assign iresp_data    = {ireq_addr[23:0], 8'h13};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        flush_tgt = 64'h0;
        zw        = 1'b1;
        ok_m      = 1'b0;
        dec_ready = 1'b1;

        #1;
        chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("rst_pc", pc, 64'h8000_0000);
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_dec_pc", dec_pc, 64'h0);
        chk("rst_dec_instr", 64'(dec_instr), 64'h0);

        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("s1_addr0", ireq_addr, 64'h8000_0000);
        chk("s1_valid0", 64'(ireq_valid), 64'd1);
        chk("s1_hold0", 64'(pc_hold), 64'd0);
        tick();
        chk("s1_addr1", ireq_addr, 64'h8000_0004);
        chk("s1_dv1", 64'(dec_valid), 64'd1);
        chk("s1_dpc1", dec_pc, 64'h8000_0000);
        chk("s1_dins1", 64'(dec_instr), 64'h0000_0013);
        tick();
        chk("s1_addr2", ireq_addr, 64'h8000_0008);
        chk("s1_dpc2", dec_pc, 64'h8000_0004);
        chk("s1_dins2", 64'(dec_instr), 64'h0000_0413);

        // Backpressure: 8000_0004 stays in the output register, 8000_0008 goes to skid.
        dec_ready = 1'b0;
        #1;
        chk("s2_hold_cap", 64'(pc_hold), 64'd1);
        tick();
        chk("s2_ireq_valid_h1", 64'(ireq_valid), 64'd0);
        chk("s2_hold_h1", 64'(pc_hold), 64'd1);
        chk("s2_dpc_h1", dec_pc, 64'h8000_0004);
        chk("s2_pc_h1", pc, 64'h8000_0008);
        tick();
        chk("s2_ireq_valid_h2", 64'(ireq_valid), 64'd0);
        chk("s2_dpc_h2", dec_pc, 64'h8000_0004);
        dec_ready = 1'b1;
        #1;
        chk("s2_hold_rel", 64'(pc_hold), 64'd0);
        tick();
        chk("s2_dpc_skid", dec_pc, 64'h8000_0008);
        chk("s2_dins_skid", 64'(dec_instr), 64'h0000_0813);
        chk("s2_addr_rel", ireq_addr, 64'h8000_000C);
        chk("s2_valid_rel", 64'(ireq_valid), 64'd1);
        tick();
        chk("s2_dpc_next", dec_pc, 64'h8000_000C);
        chk("s2_dins_next", 64'(dec_instr), 64'h0000_0C13);
        chk("s2_addr_next", ireq_addr, 64'h8000_0010);

        // 3-cycle bus with a redirect in the second request cycle.
        zw = 1'b0;
        #1;
        chk("s3_hold_wait", 64'(pc_hold), 64'd1);
        tick();
        flush     = 1'b1;
        flush_tgt = 64'h8000_0100;
        #1;
        chk("s3_hold_flush", 64'(pc_hold), 64'd0);
        chk("s3_addr_flush", ireq_addr, 64'h8000_0010);
        tick();
        flush = 1'b0;
        #1;
        chk("s3_pc_drop", pc, 64'h8000_0100);
        chk("s3_addr_drop", ireq_addr, 64'h8000_0010);
        chk("s3_valid_drop", 64'(ireq_valid), 64'd1);
        chk("s3_dv_drop", 64'(dec_valid), 64'd0);
        tick();
        ok_m = 1'b1;
        #1;
        chk("s3_addr_stale", ireq_addr, 64'h8000_0010);
        chk("s3_hold_stale", 64'(pc_hold), 64'd1);
        tick();
        ok_m = 1'b0;
        #1;
        chk("s3_addr_redir", ireq_addr, 64'h8000_0100);
        chk("s3_dv_after_stale", 64'(dec_valid), 64'd0);
        ok_m = 1'b1;
        tick();
        chk("s3_dv_tgt", 64'(dec_valid), 64'd1);
        chk("s3_dpc_tgt", dec_pc, 64'h8000_0100);
        chk("s3_dins_tgt", 64'(dec_instr), 64'h0001_0013);
        chk("s3_addr_tgt", ireq_addr, 64'h8000_0104);

        // Flush together with data_ok while the output register is full.
        dec_ready = 1'b0;
        flush     = 1'b1;
        flush_tgt = 64'h8000_0180;
        #1;
        chk("s4_hold", 64'(pc_hold), 64'd0);
        tick();
        flush = 1'b0;
        ok_m  = 1'b0;
        #1;
        chk("s4_dv", 64'(dec_valid), 64'd0);
        chk("s4_addr", ireq_addr, 64'h8000_0180);
        chk("s4_valid", 64'(ireq_valid), 64'd1);
        chk("s4_pc", pc, 64'h8000_0180);

        // Two redirects while the stale request is still outstanding.
        flush     = 1'b1;
        flush_tgt = 64'h8000_0200;
        tick();
        flush_tgt = 64'h8000_0300;
        tick();
        flush = 1'b0;
        #1;
        chk("s5_pc", pc, 64'h8000_0300);
        chk("s5_addr_old", ireq_addr, 64'h8000_0180);
        ok_m = 1'b1;
        tick();
        ok_m = 1'b0;
        #1;
        chk("s5_addr_redir", ireq_addr, 64'h8000_0300);
        chk("s5_dv_none", 64'(dec_valid), 64'd0);
        ok_m = 1'b1;
        tick();
        ok_m = 1'b0;
        chk("s5_dpc", dec_pc, 64'h8000_0300);
        chk("s5_dins", 64'(dec_instr), 64'h0003_0013);

        // Reset arriving while in DROP.
        dec_ready = 1'b1;
        flush     = 1'b1;
        flush_tgt = 64'h8000_0400;
        tick();
        flush = 1'b0;
        #1;
        chk("s6_pc_drop", pc, 64'h8000_0400);
        reset = 1'b1;
        #1;
        chk("s6_rst_valid", 64'(ireq_valid), 64'd0);
        chk("s6_rst_pc", pc, 64'h8000_0000);
        chk("s6_rst_dv", 64'(dec_valid), 64'd0);
        tick();
        reset = 1'b0;
        ok_m  = 1'b1;
        #1;
        chk("s6_addr", ireq_addr, 64'h8000_0000);
        tick();
        ok_m = 1'b0;
        chk("s6_dv", 64'(dec_valid), 64'd1);
        chk("s6_dpc", dec_pc, 64'h8000_0000);
        chk("s6_dins", 64'(dec_instr), 64'h0000_0013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
